mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the processor load/store path (cpu_*)
//  and the image DMA/reader (dma_*) that streams encrypted/decrypted pixels.
//  CPU has priority; a run-length guard bounds DMA starvation. One grant per clk.
//  Sits between processor address/writeData/WR/readData and the data RAM (1-cycle sync read).
// PARAMETERS
//  AW           8   memory word-address width
//  DW           32  data width
//  MAX_CPU_RUN  4   max consecutive CPU grants while dma_req is waiting (>=1)
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  cpu_req     in   1   CPU access request; held with addr/we/wdata until cpu_gnt
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  CPU word address
//  cpu_wdata   in   DW  CPU write data
//  cpu_gnt     out  1   CPU access accepted this cycle (combinational)
//  cpu_rvalid  out  1   cpu_rdata valid (cycle after a CPU read grant)
//  cpu_rdata   out  DW  CPU read data
//  dma_req     in   1   DMA access request; same hold rule
//  dma_we      in   1   1=write, 0=read
//  dma_addr    in   AW  DMA word address
//  dma_wdata   in   DW  DMA write data
//  dma_gnt     out  1   DMA access accepted this cycle (combinational)
//  dma_rvalid  out  1   dma_rdata valid (cycle after a DMA read grant)
//  dma_rdata   out  DW  DMA read data
//  mem_we      out  1   RAM write enable
//  mem_addr    out  AW  RAM address
//  mem_wdata   out  DW  RAM write data
//  mem_rdata   in   DW  RAM read data, valid one clk after address presented
// BEHAVIOUR
//  Reset: run_cnt=0, cpu_rvalid=dma_rvalid=0, rd_owner=none; *_rdata read 0.
//  Grant (combinational, same cycle):
//   - only cpu_req: cpu_gnt=1. only dma_req: dma_gnt=1. neither: no grant.
//   - both: CPU wins if run_cnt<MAX_CPU_RUN, else DMA wins.
//   - never both gnt=1; during rst both gnt=0, mem_we=0.
//  Memory drive: winner's addr/wdata/we on mem_*; no grant -> mem_we=0, mem_addr=0,
//   mem_wdata=0. Write completes at the grant edge; no rvalid for writes.
//  Read return: read grant at cycle N -> winner's rvalid=1 at N+1, rdata=mem_rdata;
//   non-owner rvalid=0, rdata=0. Back-to-back reads sustain 1/cycle, owners may alternate.
//  run_cnt (0..MAX_CPU_RUN, saturating):
//   - +1 on CPU grant while dma_req=1; cleared on DMA grant or when dma_req=0.
//   - holds when no grant and dma_req=1.
//  Requesters keep req and payload stable until gnt; arbiter does not latch them.
//  Reset mid-read: rvalid for the pending read is suppressed; run_cnt cleared.
//  Grant exactly 1 cycle per accepted access; a req held after gnt is a new request.
// TESTING
//  1 Reset: rst=1 2 cycles with both req=1 -> gnts=0, mem_we=0, rvalids=0; then CPU granted.
//  2 CPU read addr 0x10 (RAM=0xDEADBEEF) -> cpu_gnt cycle N, cpu_rvalid+rdata=0xDEADBEEF N+1,
//    dma_rvalid=0.
//  3 Both req continuously (MAX_CPU_RUN=4) -> grants C,C,C,C,D,C,C,C,C,D...; DMA waits <=4 cycles.
//  4 DMA write 0x55 to 0x20 while cpu_req=0 -> dma_gnt same cycle, mem_we=1; CPU read 0x20
//    next -> 0x55.
//  5 Alternating reads CPU 0x01 / DMA 0x02 back-to-back -> rvalid toggles owner each cycle,
//    data correct.
//  6 rst asserted the cycle after a CPU read grant -> cpu_rvalid stays 0, run_cnt=0 afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read data RAM port between the CPU load/store path
//   and the image DMA. The CPU has priority. A run counter limits the number of
//   consecutive CPU grants while the DMA is waiting, so the DMA waits at most
//   MAX_CPU_RUN cycles. At most one access is granted per clock.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request and payload, held until cpu_gnt
//   cpu_gnt                       CPU access accepted this cycle (combinational)
//   cpu_rvalid/rdata              CPU read data, one cycle after a read grant
//   dma_req/we/addr/wdata         DMA request and payload, held until dma_gnt
//   dma_gnt                       DMA access accepted this cycle (combinational)
//   dma_rvalid/rdata              DMA read data, one cycle after a read grant
//   mem_we/addr/wdata             RAM command, driven by the granted requester
//   mem_rdata                     RAM read data, valid one cycle after the address

module mem_port_arbiter #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 32,
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned RW = (MAX_CPU_RUN < 1) ? 1 : $clog2(MAX_CPU_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_CPU_RUN);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_e;

  logic [RW-1:0] run_cnt_q, run_cnt_d;
  rd_owner_e     rd_owner_q, rd_owner_d;
  logic          cpu_wins;

  // The CPU keeps priority until it has taken MAX_CPU_RUN grants in a row
  // while the DMA was waiting; then the DMA gets exactly one slot.
  always_comb begin
    cpu_wins = (run_cnt_q < RUN_MAX);
    cpu_gnt  = ~rst & cpu_req & (~dma_req | cpu_wins);
    dma_gnt  = ~rst & dma_req & (~cpu_req | ~cpu_wins);
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (dma_gnt || !dma_req) begin
      run_cnt_d = '0;
    end else if (cpu_gnt && (run_cnt_q < RUN_MAX)) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end

    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && !dma_we) begin
      rd_owner_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q  <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      run_cnt_q  <= run_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Gating with rst drops the return of a read granted just before reset.
  always_comb begin
    cpu_rvalid = ~rst & (rd_owner_q == OWN_CPU);
    dma_rvalid = ~rst & (rd_owner_q == OWN_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(32), .MAX_CPU_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // 1-cycle synchronous-read RAM
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic        rst;
    logic        creq; logic cwe; logic [7:0] caddr; logic [31:0] cwd;
    logic        dreq; logic dwe; logic [7:0] daddr; logic [31:0] dwd;
    logic        e_cg; logic e_dg; logic e_mwe; logic [7:0] e_maddr; logic [31:0] e_mwd;
    logic        e_crv; logic [31:0] e_crd; logic e_drv; logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic creq, input logic cwe, input logic [7:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [7:0] daddr, input logic [31:0] dwd);
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_no_both(input int idx);
    chk("gnt_exclusive", idx, {31'd0, cpu_gnt & dma_gnt}, 32'd0);
  endtask

  initial begin
    // rst creq cwe caddr cwd dreq dwe daddr dwd | cg dg mwe maddr mwd | crv crd drv drd
    vecs.push_back('{1,1,1,8'h10,32'hDEADBEEF,1,1,8'h02,32'h22222222, 0,0,0,8'h00,32'h0, 0,32'h0,0,32'h0});
    vecs.push_back('{1,1,1,8'h10,32'hDEADBEEF,1,1,8'h02,32'h22222222, 0,0,0,8'h00,32'h0, 0,32'h0,0,32'h0});
    vecs.push_back('{0,1,1,8'h10,32'hDEADBEEF,1,1,8'h02,32'h22222222, 1,0,1,8'h10,32'hDEADBEEF, 0,32'h0,0,32'h0});
    vecs.push_back('{0,1,1,8'h01,32'h11111111,1,1,8'h02,32'h22222222, 1,0,1,8'h01,32'h11111111, 0,32'h0,0,32'h0});
    vecs.push_back('{0,0,0,8'h00,32'h0,       1,1,8'h02,32'h22222222, 0,1,1,8'h02,32'h22222222, 0,32'h0,0,32'h0});
    vecs.push_back('{0,0,0,8'h00,32'h0,       1,1,8'h20,32'h00000055, 0,1,1,8'h20,32'h00000055, 0,32'h0,0,32'h0});
    vecs.push_back('{0,1,0,8'h20,32'h0,       0,0,8'h00,32'h0,        1,0,0,8'h20,32'h0, 0,32'h0,0,32'h0});
    vecs.push_back('{0,1,0,8'h10,32'h0,       0,0,8'h00,32'h0,        1,0,0,8'h10,32'h0, 1,32'h00000055,0,32'h0});
    vecs.push_back('{0,1,0,8'h01,32'h0,       1,0,8'h02,32'h0,        1,0,0,8'h01,32'h0, 1,32'hDEADBEEF,0,32'h0});
    vecs.push_back('{0,0,0,8'h00,32'h0,       1,0,8'h02,32'h0,        0,1,0,8'h02,32'h0, 1,32'h11111111,0,32'h0});
    vecs.push_back('{0,1,0,8'h10,32'h0,       0,0,8'h00,32'h0,        1,0,0,8'h10,32'h0, 0,32'h0,1,32'h22222222});
    vecs.push_back('{0,0,0,8'h00,32'h0,       1,0,8'h01,32'h0,        0,1,0,8'h01,32'h0, 1,32'hDEADBEEF,0,32'h0});
    vecs.push_back('{0,0,0,8'h00,32'h0,       0,0,8'h00,32'h0,        0,0,0,8'h00,32'h0, 0,32'h0,1,32'h11111111});
    vecs.push_back('{0,0,0,8'h00,32'h0,       0,0,8'h00,32'h0,        0,0,0,8'h00,32'h0, 0,32'h0,0,32'h0});

    drive(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
      @(negedge clk);
      n_vec++;
      chk("cpu_gnt",    i, {31'd0, cpu_gnt},    {31'd0, vecs[i].e_cg});
      chk("dma_gnt",    i, {31'd0, dma_gnt},    {31'd0, vecs[i].e_dg});
      chk("mem_we",     i, {31'd0, mem_we},     {31'd0, vecs[i].e_mwe});
      chk("mem_addr",   i, {24'd0, mem_addr},   {24'd0, vecs[i].e_maddr});
      chk("mem_wdata",  i, mem_wdata,           vecs[i].e_mwd);
      chk("cpu_rvalid", i, {31'd0, cpu_rvalid}, {31'd0, vecs[i].e_crv});
      chk("cpu_rdata",  i, cpu_rdata,           vecs[i].e_crd);
      chk("dma_rvalid", i, {31'd0, dma_rvalid}, {31'd0, vecs[i].e_drv});
      chk("dma_rdata",  i, dma_rdata,           vecs[i].e_drd);
      next_cycle();
    end

    // Both requesting continuously: C,C,C,C,D repeating, read data follows the owner.
    begin
      logic prev_c;
      prev_c = 1'b0;
      for (int i = 0; i < 10; i++) begin
        logic exp_c;
        exp_c = ((i % 5) != 4);
        drive(0, 1, 0, 8'h10, 32'h0, 1, 0, 8'h02, 32'h0);
        @(negedge clk);
        n_vec++;
        chk("run_cpu_gnt", 100 + i, {31'd0, cpu_gnt}, {31'd0, exp_c});
        chk("run_dma_gnt", 100 + i, {31'd0, dma_gnt}, {31'd0, ~exp_c});
        chk_no_both(100 + i);
        if (i > 0) begin
          chk("run_cpu_rvalid", 100 + i, {31'd0, cpu_rvalid}, {31'd0, prev_c});
          chk("run_dma_rvalid", 100 + i, {31'd0, dma_rvalid}, {31'd0, ~prev_c});
          chk("run_cpu_rdata",  100 + i, cpu_rdata, prev_c ? 32'hDEADBEEF : 32'h0);
          chk("run_dma_rdata",  100 + i, dma_rdata, prev_c ? 32'h0 : 32'h22222222);
        end
        prev_c = exp_c;
        next_cycle();
      end
    end

    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    next_cycle();

    // Reset the cycle after a CPU read grant: return suppressed, run counter cleared.
    drive(0, 1, 0, 8'h10, 32'h0, 1, 0, 8'h02, 32'h0);
    @(negedge clk);
    n_vec++;
    chk("pre_rst_cpu_gnt", 200, {31'd0, cpu_gnt}, 32'd1);
    next_cycle();
    drive(1, 1, 0, 8'h10, 32'h0, 1, 0, 8'h02, 32'h0);
    @(negedge clk);
    n_vec++;
    chk("rst_cpu_rvalid", 201, {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_cpu_rdata",  201, cpu_rdata, 32'h0);
    chk("rst_cpu_gnt",    201, {31'd0, cpu_gnt}, 32'd0);
    chk("rst_dma_gnt",    201, {31'd0, dma_gnt}, 32'd0);
    chk("rst_mem_we",     201, {31'd0, mem_we},  32'd0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      logic exp_c;
      exp_c = (i != 4);
      drive(0, 1, 0, 8'h10, 32'h0, 1, 0, 8'h02, 32'h0);
      @(negedge clk);
      n_vec++;
      chk("post_rst_cpu_gnt", 210 + i, {31'd0, cpu_gnt}, {31'd0, exp_c});
      chk("post_rst_dma_gnt", 210 + i, {31'd0, dma_gnt}, {31'd0, ~exp_c});
      if (i == 0) begin
        chk("post_rst_cpu_rvalid", 210, {31'd0, cpu_rvalid}, 32'd0);
        chk("post_rst_dma_rvalid", 210, {31'd0, dma_rvalid}, 32'd0);
      end
      next_cycle();
    end

    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
